// File: rtl/elm_layer_sequencer.sv
// elm_layer_sequencer
// Sequences one hidden layer of neurons. It loads per-neuron weights and biases
// from a config stream. It then broadcasts each input vector to every neuron,
// collects one result per neuron and drains the results in neuron-index order.
module elm_layer_sequencer #(
   parameter int LAYER_NO   = 1,
   parameter int NUM_NEURON = 30,
   parameter int NUM_WEIGHT = 128,
   parameter int DATA_W     = 16,
   parameter int OUT_W      = 16,
   parameter int TIMEOUT    = 512
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_start,
   input  logic [DATA_W-1:0]           cfg_data,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [DATA_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        weight_valid,
   output logic [DATA_W-1:0]           weight_value,
   output logic [NUM_NEURON-1:0]       bias_valid,
   output logic [DATA_W-1:0]           bias_value,
   output logic [2*DATA_W:0]           config_layer_num,
   output logic [2*DATA_W:0]           config_neuron_num,
   output logic [DATA_W-1:0]           my_input,
   output logic                        my_input_valid,
   input  logic [NUM_NEURON-1:0]       neuron_outvalid,
   input  logic [NUM_NEURON*OUT_W-1:0] neuron_out,
   output logic [OUT_W-1:0]            out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        cfg_done,
   output logic                        busy,
   output logic                        err_timeout
);

   localparam int CN_W = 2*DATA_W + 1;
   localparam int N_W  = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
   localparam int W_W  = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
   localparam int T_W  = (TIMEOUT > 1)    ? $clog2(TIMEOUT)    : 1;

   localparam logic [N_W-1:0]        N_LAST   = N_W'(NUM_NEURON - 1);
   localparam logic [W_W-1:0]        W_LAST   = W_W'(NUM_WEIGHT - 1);
   localparam logic [T_W-1:0]        T_LAST   = T_W'(TIMEOUT - 1);
   localparam logic [NUM_NEURON-1:0] NEURON0  = NUM_NEURON'(1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_W   = 3'd1;
   localparam logic [2:0] S_LOAD_B   = 3'd2;
   localparam logic [2:0] S_READY    = 3'd3;
   localparam logic [2:0] S_STREAM   = 3'd4;
   localparam logic [2:0] S_WAIT_OUT = 3'd5;
   localparam logic [2:0] S_DRAIN    = 3'd6;

   logic [2:0]            state;
   logic [N_W-1:0]        n;        // neuron being loaded
   logic [W_W-1:0]        w;        // weight index within the neuron
   logic [W_W-1:0]        k;        // input elements accepted in this vector
   logic [N_W-1:0]        j;        // drain index
   logic [T_W-1:0]        timer;    // cycles spent in WAIT_OUT
   logic [NUM_NEURON-1:0] mask;     // which neuron results have been captured
   logic [NUM_NEURON-1:0] mask_next;
   logic [OUT_W-1:0]      cap [NUM_NEURON];

   logic cfg_fire;
   logic in_fire;
   logic in_take;

   assign cfg_ready        = (state == S_LOAD_W) || (state == S_LOAD_B);
   assign in_ready         = (state == S_READY)  || (state == S_STREAM);
   assign out_valid        = (state == S_DRAIN);
   assign busy             = (state == S_LOAD_W) || (state == S_LOAD_B) || (state == S_STREAM) ||
                             (state == S_WAIT_OUT) || (state == S_DRAIN);
   assign config_layer_num = CN_W'(LAYER_NO);

   assign cfg_fire  = cfg_valid && cfg_ready;
   assign in_fire   = in_valid && in_ready;
   // A reload request in READY wins over a coincident input word, which is then dropped
   // so that every broadcast strobe belongs to a counted vector element.
   assign in_take   = in_fire && !((state == S_READY) && cfg_start);
   assign mask_next = mask | neuron_outvalid;

   // Control FSM: load sequencing, vector counting, result collection and drain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         n           <= '0;
         w           <= '0;
         k           <= '0;
         j           <= '0;
         timer       <= '0;
         mask        <= '0;
         cfg_done    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         err_timeout <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cfg_start) begin
                  n     <= '0;
                  w     <= '0;
                  state <= S_LOAD_W;
               end
            end
            S_LOAD_W: begin
               if (cfg_fire) begin
                  if (w == W_LAST) begin
                     w     <= '0;
                     state <= S_LOAD_B;
                  end else begin
                     w <= w + 1'b1;
                  end
               end
            end
            S_LOAD_B: begin
               if (cfg_fire) begin
                  if (n == N_LAST) begin
                     cfg_done <= 1'b1;
                     state    <= S_READY;
                  end else begin
                     n     <= n + 1'b1;
                     w     <= '0;
                     state <= S_LOAD_W;
                  end
               end
            end
            S_READY, S_STREAM: begin
               if ((state == S_READY) && cfg_start) begin
                  cfg_done <= 1'b0;
                  n        <= '0;
                  w        <= '0;
                  state    <= S_LOAD_W;
               end else if (in_take) begin
                  if (k == W_LAST) begin
                     k     <= '0;
                     timer <= '0;
                     state <= S_WAIT_OUT;
                  end else begin
                     k     <= k + 1'b1;
                     state <= S_STREAM;
                  end
               end
            end
            S_WAIT_OUT: begin
               mask <= mask_next;
               if (&mask_next) begin
                  state <= S_DRAIN;
               end else if (timer == T_LAST) begin
                  err_timeout <= 1'b1;
                  state       <= S_DRAIN;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (j == N_LAST) begin
                     j     <= '0;
                     mask  <= '0;
                     state <= S_READY;
                  end else begin
                     j <= j + 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Neuron-side strobes: one registered strobe per accepted config or input word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         weight_valid      <= 1'b0;
         weight_value      <= '0;
         bias_valid        <= '0;
         bias_value        <= '0;
         config_neuron_num <= '0;
         my_input_valid    <= 1'b0;
         my_input          <= '0;
      end else begin
         weight_valid   <= 1'b0;
         bias_valid     <= '0;
         my_input_valid <= 1'b0;
         if ((state == S_LOAD_W) && cfg_fire) begin
            weight_valid      <= 1'b1;
            weight_value      <= cfg_data;
            config_neuron_num <= CN_W'(n);
         end
         if ((state == S_LOAD_B) && cfg_fire) begin
            bias_valid <= NEURON0 << n;
            bias_value <= cfg_data;
         end
         if (in_take) begin
            my_input_valid <= 1'b1;
            my_input       <= in_data;
         end
      end
   end

   // Result capture: every neuron pulsing during WAIT_OUT is latched that cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_NEURON; i++) cap[i] <= '0;
      end else if (state == S_WAIT_OUT) begin
         for (int i = 0; i < NUM_NEURON; i++) begin
            if (neuron_outvalid[i]) cap[i] <= neuron_out[i*OUT_W +: OUT_W];
         end
      end
   end

   // Drain mux: entries never captured (timeout) read as zero.
   always_comb begin
      out_data = '0;
      if ((state == S_DRAIN) && mask[j]) out_data = cap[j];
   end

endmodule

// File: tb/tb_elm_layer_sequencer.sv
// Testbench for elm_layer_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of the layer controller.
module tb_elm_layer_sequencer;

   localparam int NN  = 3;
   localparam int NW  = 4;
   localparam int TO  = 20;
   localparam int DW  = 16;
   localparam int OW  = 16;
   localparam int LN  = 1;
   localparam int WPN = NW + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cfg_start = 1'b0;
   logic [DW-1:0]     cfg_data = '0;
   logic              cfg_valid = 1'b0;
   logic              cfg_ready;
   logic [DW-1:0]     in_data = '0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              weight_valid;
   logic [DW-1:0]     weight_value;
   logic [NN-1:0]     bias_valid;
   logic [DW-1:0]     bias_value;
   logic [2*DW:0]     config_layer_num;
   logic [2*DW:0]     config_neuron_num;
   logic [DW-1:0]     my_input;
   logic              my_input_valid;
   logic [NN-1:0]     neuron_outvalid = '0;
   logic [NN*OW-1:0]  neuron_out = '0;
   logic [OW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic              cfg_done;
   logic              busy;
   logic              err_timeout;

   elm_layer_sequencer #(
      .LAYER_NO(LN), .NUM_NEURON(NN), .NUM_WEIGHT(NW),
      .DATA_W(DW), .OUT_W(OW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_start(cfg_start), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .weight_valid(weight_valid), .weight_value(weight_value),
      .bias_valid(bias_valid), .bias_value(bias_value),
      .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
      .my_input(my_input), .my_input_valid(my_input_valid),
      .neuron_outvalid(neuron_outvalid), .neuron_out(neuron_out),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .cfg_done(cfg_done), .busy(busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int mis = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // phase: 0 idle, 1 loading, 2 accepting a vector, 3 waiting for results, 4 draining
   int           m_phase, load_idx, in_cnt, wait_cyc, drain_j;
   logic         m_done;
   logic [2*DW:0] m_cnn;
   logic [OW-1:0] res [NN];
   logic [NN-1:0] got;
   logic          e_wv, e_iv, e_err;
   logic [DW-1:0] e_wval, e_bval, e_ival;
   logic [NN-1:0] e_bv;

   // observation logs for literal pins
   int obs_w[$], obs_n[$], obs_b[$], obs_bm[$], obs_out[$];
   int n_iv = 0, n_err = 0;

   task automatic model_reset();
      m_phase = 0; load_idx = 0; in_cnt = 0; wait_cyc = 0; drain_j = 0;
      m_done = 1'b0; m_cnn = '0; got = '0;
      e_wv = 1'b0; e_iv = 1'b0; e_err = 1'b0; e_bv = '0;
      e_wval = '0; e_bval = '0; e_ival = '0;
      for (int i = 0; i < NN; i++) res[i] = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_weight_valid"}, weight_valid, 0);
      chk({tag, "_weight_value"}, weight_value, 0);
      chk({tag, "_bias_valid"}, bias_valid, 0);
      chk({tag, "_bias_value"}, bias_value, 0);
      chk({tag, "_neuron_num"}, config_neuron_num, 0);
      chk({tag, "_layer_num"}, config_layer_num, LN);
      chk({tag, "_my_input"}, my_input, 0);
      chk({tag, "_my_input_valid"}, my_input_valid, 0);
      chk({tag, "_out_data"}, out_data, 0);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_cfg_ready"}, cfg_ready, 0);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_cfg_done"}, cfg_done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   initial model_reset();

   // Compare process: outputs after each rising edge against the model, then advance
   // the model with the inputs that the next rising edge will sample.
   always @(negedge clk) begin
      if (!rst) begin
         check_reset_outputs("rst");
         model_reset();
      end else begin
         chk("cfg_ready", cfg_ready, m_phase == 1);
         chk("in_ready", in_ready, m_phase == 2);
         chk("out_valid", out_valid, m_phase == 4);
         if (m_phase == 4) chk("out_data", out_data, res[drain_j]);
         chk("busy", busy, (m_phase == 1) || (m_phase == 3) || (m_phase == 4) ||
                           ((m_phase == 2) && (in_cnt > 0)));
         chk("cfg_done", cfg_done, m_done);
         chk("err_timeout", err_timeout, e_err);
         chk("weight_valid", weight_valid, e_wv);
         if (e_wv) chk("weight_value", weight_value, e_wval);
         chk("config_neuron_num", config_neuron_num, m_cnn);
         chk("config_layer_num", config_layer_num, LN);
         chk("bias_valid", bias_valid, e_bv);
         if (e_bv != 0) chk("bias_value", bias_value, e_bval);
         chk("my_input_valid", my_input_valid, e_iv);
         if (e_iv) chk("my_input", my_input, e_ival);

         if (weight_valid) begin
            obs_w.push_back(int'(weight_value));
            obs_n.push_back(int'(config_neuron_num));
         end
         if (bias_valid != 0) begin
            obs_b.push_back(int'(bias_value));
            obs_bm.push_back(int'(bias_valid));
         end
         if (out_valid && out_ready) obs_out.push_back(int'(out_data));
         if (my_input_valid) n_iv++;
         if (err_timeout) n_err++;

         e_wv = 1'b0; e_bv = '0; e_iv = 1'b0; e_err = 1'b0;
         case (m_phase)
            0: if (cfg_start) begin m_phase = 1; load_idx = 0; end
            1: if (cfg_valid) begin
                  if ((load_idx % WPN) < NW) begin
                     e_wv = 1'b1; e_wval = cfg_data; m_cnn = (2*DW+1)'(load_idx / WPN);
                  end else begin
                     e_bv = NN'(1) << (load_idx / WPN); e_bval = cfg_data;
                  end
                  load_idx++;
                  if (load_idx == NN*WPN) begin m_phase = 2; m_done = 1'b1; in_cnt = 0; end
               end
            2: if (cfg_start && in_cnt == 0) begin
                  m_done = 1'b0; m_phase = 1; load_idx = 0;
               end else if (in_valid) begin
                  e_iv = 1'b1; e_ival = in_data; in_cnt++;
                  if (in_cnt == NW) begin
                     m_phase = 3; wait_cyc = 0; got = '0;
                     for (int i = 0; i < NN; i++) res[i] = '0;
                  end
               end
            3: begin
                  for (int i = 0; i < NN; i++) begin
                     if (neuron_outvalid[i]) begin
                        res[i] = neuron_out[i*OW +: OW]; got[i] = 1'b1;
                     end
                  end
                  wait_cyc++;
                  if (&got) begin m_phase = 4; drain_j = 0; end
                  else if (wait_cyc == TO) begin e_err = 1'b1; m_phase = 4; drain_j = 0; end
               end
            4: if (out_ready) begin
                  drain_j++;
                  if (drain_j == NN) begin m_phase = 2; in_cnt = 0; end
               end
            default: m_phase = 0;
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_words(input bit toggle);
      bit ph;
      bit acc;
      int guard;
      obs_w.delete(); obs_n.delete(); obs_b.delete(); obs_bm.delete();
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      ph = 1'b1;
      for (int wd = 0; wd < NN*WPN; wd++) begin
         acc = 1'b0;
         guard = 0;
         cfg_data = DW'(wd + 1);
         while (!acc && guard < 20) begin
            cfg_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            acc = cfg_valid && cfg_ready;
            step();
            guard++;
         end
         if (!acc) chk("load_handshake_bound", 0, 1);
      end
      cfg_valid = 1'b0;
      step();
   endtask

   task automatic check_load_log();
      int ew[12]  = '{1, 2, 3, 4, 6, 7, 8, 9, 11, 12, 13, 14};
      int en[12]  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};
      int eb[3]   = '{5, 10, 15};
      int ebm[3]  = '{1, 2, 4};
      chk("n_weight_strobes", obs_w.size(), 12);
      chk("n_bias_strobes", obs_b.size(), 3);
      for (int i = 0; i < 12; i++) begin
         if (i < obs_w.size()) begin
            chk("log_weight", obs_w[i], ew[i]);
            chk("log_neuron", obs_n[i], en[i]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (i < obs_b.size()) begin
            chk("log_bias", obs_b[i], eb[i]);
            chk("log_bias_onehot", obs_bm[i], ebm[i]);
         end
      end
      chk("cfg_done_after_load", cfg_done, 1);
   endtask

   task automatic stream_vec(input int gap, input logic [DW-1:0] base);
      bit acc;
      int guard;
      for (int i = 0; i < NW; i++) begin
         acc = 1'b0;
         guard = 0;
         in_valid = 1'b1;
         in_data = base + DW'(i);
         while (!acc && guard < 20) begin
            acc = in_ready;
            step();
            guard++;
         end
         if (!acc) chk("stream_handshake_bound", 0, 1);
         in_valid = 1'b0;
         if (i == NW-1) chk("in_ready_after_last", in_ready, 0);
         repeat (gap) step();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   int lat;

   initial begin
      repeat (3) step();
      check_reset_outputs("init");
      rst = 1'b1;
      step();

      // load without stalls
      load_words(1'b0);
      check_load_log();

      // reload from READY with cfg_valid toggling every cycle
      load_words(1'b1);
      check_load_log();

      // vector with 2-cycle gaps; outvalid in READY must be ignored
      n_iv = 0;
      obs_out.delete();
      neuron_out = {16'hdead, 16'hbeef, 16'hcafe};
      neuron_outvalid = '1;
      step();
      neuron_outvalid = '0;
      stream_vec(2, 16'h0100);
      chk("my_input_pulses", n_iv, 4);
      neuron_out = {16'h3333, 16'h2222, 16'h1111};
      neuron_outvalid = 3'b100;
      step();
      neuron_outvalid = 3'b011;
      step();
      neuron_outvalid = '0;
      out_ready = 1'b0;
      repeat (5) begin
         chk("stall_out_valid", out_valid, 1);
         chk("stall_out_data", out_data, 16'h1111);
         step();
      end
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      step();
      chk("drain_count", obs_out.size(), 3);
      if (obs_out.size() == 3) begin
         chk("drain0", obs_out[0], 16'h1111);
         chk("drain1", obs_out[1], 16'h2222);
         chk("drain2", obs_out[2], 16'h3333);
      end
      chk("ready_after_drain", in_ready, 1);
      chk("idle_after_drain", busy, 0);

      // timeout: only neuron 1 answers
      obs_out.delete();
      n_err = 0;
      stream_vec(0, 16'h0200);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 3) begin
            neuron_outvalid = 3'b010;
            neuron_out = {16'h0000, 16'h0abc, 16'h0000};
         end else begin
            neuron_outvalid = '0;
         end
         step();
         if (err_timeout) begin
            lat = c;
            break;
         end
      end
      neuron_outvalid = '0;
      chk("timeout_latency", lat, TO);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      step();
      chk("timeout_err_pulses", n_err, 1);
      chk("timeout_drain_count", obs_out.size(), 3);
      if (obs_out.size() == 3) begin
         chk("timeout_drain0", obs_out[0], 0);
         chk("timeout_drain1", obs_out[1], 16'h0abc);
         chk("timeout_drain2", obs_out[2], 0);
      end

      // asynchronous reset in the middle of a load
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      cfg_valid = 1'b1;
      for (int wd = 1; wd <= 7; wd++) begin
         cfg_data = DW'(wd);
         step();
      end
      cfg_valid = 1'b0;
      chk("pre_reset_weight", weight_value, 7);
      chk("pre_reset_neuron", config_neuron_num, 1);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("async");
      step();
      step();
      rst = 1'b1;
      step();
      load_words(1'b0);
      check_load_log();

      // randomized traffic
      for (int c = 0; c < 1500; c++) begin
         cfg_start = ($urandom_range(0, 39) == 0);
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_data  = DW'($urandom);
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = DW'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NN; i++) neuron_outvalid[i] = ($urandom_range(0, 7) == 0);
         neuron_out = (NN*OW)'({$urandom, $urandom});
         step();
      end
      cfg_start = 1'b0; cfg_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      neuron_outvalid = '0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
